// File: rtl/cpu_pkg.sv
// Shared opcode map, sequencer state encoding and control-strobe bundle
// for the accumulator processor control path.
package cpu_pkg;

  localparam int unsigned OPC_NOP   = 0;
  localparam int unsigned OPC_LOAD  = 1;
  localparam int unsigned OPC_STORE = 2;
  localparam int unsigned OPC_ADD   = 3;
  localparam int unsigned OPC_SUB   = 4;
  localparam int unsigned OPC_AND   = 5;
  localparam int unsigned OPC_OR    = 6;
  localparam int unsigned OPC_BNE   = 7;
  localparam int unsigned OPC_BEQ   = 8;
  localparam int unsigned OPC_JMP   = 9;
  localparam int unsigned OPC_HALT  = 15;

  typedef enum logic [3:0] {
    ST_FETCH_A,
    ST_FETCH_M,
    ST_FETCH_I,
    ST_DECODE,
    ST_RD_A,
    ST_RD_M,
    ST_EXEC,
    ST_WR_D,
    ST_WR_M0,
    ST_WR_M,
    ST_BRANCH,
    ST_HALT,
    ST_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic    acc_bus;
    logic    load_acc;
    logic    pc_bus;
    logic    load_pc;
    logic    inc_pc;
    logic    load_ir;
    logic    load_mar;
    logic    mdr_bus;
    logic    load_mdr;
    logic    addr_bus;
    logic    alu_acc;
    alu_op_t alu_op;
    logic    cs;
    logic    r_nw;
    logic    halted;
    logic    bus_error;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags the
// cycle on which one more wait would exceed MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Any cycle outside a memory state, or a completed access, restarts the count.
  always_ff @(posedge clock) begin
    if (reset || !active || ready) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(MAX_WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout = active && !ready && (r_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/sequencer_ws.sv
// Control sequencer with wait-state memory handshake. Strobes are registered
// from the next state, so they always match the current state after the first post-reset cycle.
module sequencer_ws
  import cpu_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            load_MAR,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            Addr_bus,
  output logic            ALU_ACC,
  output logic [1:0]      ALU_op,
  output logic            CS,
  output logic            R_NW,
  output logic            halted,
  output logic            bus_error
);

  seq_state_t r_state;
  seq_state_t w_next;
  ctrl_t      r_ctrl;
  logic       w_mem_active;
  logic       w_timeout;

  function automatic logic op_is(input logic [OP_W-1:0] o, input int unsigned code);
    return o == OP_W'(code);
  endfunction

  function automatic logic is_alu(input logic [OP_W-1:0] o);
    return op_is(o, OPC_ADD) || op_is(o, OPC_SUB) || op_is(o, OPC_AND) || op_is(o, OPC_OR);
  endfunction

  function automatic alu_op_t alu_sel(input logic [OP_W-1:0] o);
    if (op_is(o, OPC_SUB)) return ALU_SUB;
    if (op_is(o, OPC_AND)) return ALU_AND;
    if (op_is(o, OPC_OR))  return ALU_OR;
    return ALU_ADD;
  endfunction

  function automatic ctrl_t decode_ctrl(input seq_state_t s, input logic [OP_W-1:0] o);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH_A: begin c.pc_bus = 1'b1; c.load_mar = 1'b1; c.inc_pc = 1'b1; c.load_pc = 1'b1; end
      ST_FETCH_M: begin c.cs = 1'b1; c.r_nw = 1'b1; end
      ST_FETCH_I: begin c.mdr_bus = 1'b1; c.load_ir = 1'b1; end
      ST_RD_A:    begin c.addr_bus = 1'b1; c.load_mar = 1'b1; end
      ST_RD_M:    begin c.cs = 1'b1; c.r_nw = 1'b1; end
      ST_EXEC: begin
        c.mdr_bus  = 1'b1;
        c.load_acc = 1'b1;
        if (is_alu(o)) begin
          c.alu_acc = 1'b1;
          c.alu_op  = alu_sel(o);
        end
      end
      ST_WR_D:    begin c.addr_bus = 1'b1; c.load_mar = 1'b1; end
      ST_WR_M0:   begin c.acc_bus = 1'b1; c.load_mdr = 1'b1; end
      ST_WR_M:    c.cs = 1'b1;
      ST_BRANCH:  begin c.addr_bus = 1'b1; c.load_pc = 1'b1; end
      ST_HALT:    c.halted = 1'b1;
      ST_ERROR:   c.bus_error = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign w_mem_active = (r_state == ST_FETCH_M) || (r_state == ST_RD_M) || (r_state == ST_WR_M);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .active  (w_mem_active),
    .ready   (mem_ready),
    .timeout (w_timeout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH_A: w_next = ST_FETCH_M;
      ST_FETCH_M: w_next = w_timeout ? ST_ERROR : (mem_ready ? ST_FETCH_I : ST_FETCH_M);
      ST_FETCH_I: w_next = ST_DECODE;
      ST_DECODE: begin
        if (op_is(op, OPC_HALT))
          w_next = ST_HALT;
        else if (op_is(op, OPC_JMP) || (op_is(op, OPC_BNE) && !z_flag) || (op_is(op, OPC_BEQ) && z_flag))
          w_next = ST_BRANCH;
        else if (op_is(op, OPC_LOAD) || is_alu(op))
          w_next = ST_RD_A;
        else if (op_is(op, OPC_STORE))
          w_next = ST_WR_D;
        else
          w_next = ST_FETCH_A;
      end
      ST_RD_A:    w_next = ST_RD_M;
      ST_RD_M:    w_next = w_timeout ? ST_ERROR : (mem_ready ? ST_EXEC : ST_RD_M);
      ST_EXEC:    w_next = ST_FETCH_A;
      ST_WR_D:    w_next = ST_WR_M0;
      ST_WR_M0:   w_next = ST_WR_M;
      ST_WR_M:    w_next = w_timeout ? ST_ERROR : (mem_ready ? ST_FETCH_A : ST_WR_M);
      ST_BRANCH:  w_next = ST_FETCH_A;
      ST_HALT:    w_next = ST_HALT;
      ST_ERROR:   w_next = ST_ERROR;
      default:    w_next = ST_FETCH_A;
    endcase
  end

  // Reset clears the strobes too, so the first FETCH_A after reset is quiet.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH_A;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_ctrl(w_next, op);
    end
  end

  assign ACC_bus   = r_ctrl.acc_bus;
  assign load_ACC  = r_ctrl.load_acc;
  assign PC_bus    = r_ctrl.pc_bus;
  assign load_PC   = r_ctrl.load_pc;
  assign INC_PC    = r_ctrl.inc_pc;
  assign load_IR   = r_ctrl.load_ir;
  assign load_MAR  = r_ctrl.load_mar;
  assign MDR_bus   = r_ctrl.mdr_bus;
  assign load_MDR  = r_ctrl.load_mdr;
  assign Addr_bus  = r_ctrl.addr_bus;
  assign ALU_ACC   = r_ctrl.alu_acc;
  assign ALU_op    = r_ctrl.alu_op;
  assign CS        = r_ctrl.cs;
  assign R_NW      = r_ctrl.r_nw;
  assign halted    = r_ctrl.halted;
  assign bus_error = r_ctrl.bus_error;

endmodule

// File: tb/tb_sequencer_ws.sv
// Bench for sequencer_ws: an instruction-level model expands each opcode into
// its per-cycle strobe pattern, ready and z stimulus, checked cycle by cycle.
module tb_sequencer_ws;
  import cpu_pkg::*;

  localparam int MAX_WAIT = 15;

  // Strobe bit positions in the observed vector
  localparam logic [16:0] B_ACC_BUS  = 17'd1 << 16;
  localparam logic [16:0] B_LOAD_ACC = 17'd1 << 15;
  localparam logic [16:0] B_PC_BUS   = 17'd1 << 14;
  localparam logic [16:0] B_LOAD_PC  = 17'd1 << 13;
  localparam logic [16:0] B_INC_PC   = 17'd1 << 12;
  localparam logic [16:0] B_LOAD_IR  = 17'd1 << 11;
  localparam logic [16:0] B_LOAD_MAR = 17'd1 << 10;
  localparam logic [16:0] B_MDR_BUS  = 17'd1 << 9;
  localparam logic [16:0] B_LOAD_MDR = 17'd1 << 8;
  localparam logic [16:0] B_ADDR_BUS = 17'd1 << 7;
  localparam logic [16:0] B_ALU_ACC  = 17'd1 << 6;
  localparam logic [16:0] B_CS       = 17'd1 << 3;
  localparam logic [16:0] B_R_NW     = 17'd1 << 2;
  localparam logic [16:0] B_HALTED   = 17'd1 << 1;
  localparam logic [16:0] B_BUS_ERR  = 17'd1;

  localparam logic [16:0] P_FA   = B_PC_BUS | B_LOAD_MAR | B_INC_PC | B_LOAD_PC;
  localparam logic [16:0] P_RDM  = B_CS | B_R_NW;
  localparam logic [16:0] P_FI   = B_MDR_BUS | B_LOAD_IR;
  localparam logic [16:0] P_ADDR = B_ADDR_BUS | B_LOAD_MAR;
  localparam logic [16:0] P_EX   = B_MDR_BUS | B_LOAD_ACC;
  localparam logic [16:0] P_WM0  = B_ACC_BUS | B_LOAD_MDR;
  localparam logic [16:0] P_BR   = B_ADDR_BUS | B_LOAD_PC;

  logic       clock, reset, z_flag, mem_ready;
  logic [3:0] op;
  logic       ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, load_MAR;
  logic       MDR_bus, load_MDR, Addr_bus, ALU_ACC, CS, R_NW, halted, bus_error;
  logic [1:0] ALU_op;
  logic [16:0] obs;

  logic [16:0] exp_q[$];
  bit          rdy_q[$];
  bit          z_q[$];
  logic [3:0]  op_q[$];
  int          checks, failures;
  bit          first_pending;

  sequencer_ws #(.OP_W(4), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag), .mem_ready(mem_ready),
    .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
    .INC_PC(INC_PC), .load_IR(load_IR), .load_MAR(load_MAR), .MDR_bus(MDR_bus),
    .load_MDR(load_MDR), .Addr_bus(Addr_bus), .ALU_ACC(ALU_ACC), .ALU_op(ALU_op),
    .CS(CS), .R_NW(R_NW), .halted(halted), .bus_error(bus_error)
  );

  assign obs = {ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, load_MAR, MDR_bus,
                load_MDR, Addr_bus, ALU_ACC, ALU_op, CS, R_NW, halted, bus_error};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [16:0] p, input bit r, input bit z, input logic [3:0] o);
    exp_q.push_back(p);
    rdy_q.push_back(r);
    z_q.push_back(z);
    op_q.push_back(o);
  endtask

  // One memory access with w not-ready cycles; beyond MAX_WAIT it never completes.
  task automatic push_mem(input logic [16:0] p, input int w, input logic [3:0] o, output bit err);
    err = 1'b0;
    if (w > MAX_WAIT) begin
      for (int i = 0; i <= MAX_WAIT; i++) push(p, 1'b0, rb(), o);
      err = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(p, 1'b0, rb(), o);
      push(p, 1'b1, rb(), o);
    end
  endtask

  task automatic build(input logic [3:0] o, input bit z, input int wf, input int wx, input int tail);
    bit err;
    bit taken;
    bit alu;
    logic [16:0] fa;
    logic [16:0] ex;
    fa = first_pending ? 17'd0 : P_FA;
    first_pending = 1'b0;
    push(fa, rb(), rb(), o);
    push_mem(P_RDM, wf, o, err);
    if (err) begin
      for (int i = 0; i < tail; i++) push(B_BUS_ERR, rb(), rb(), o);
      return;
    end
    push(P_FI, rb(), rb(), o);
    push(17'd0, rb(), z, o);
    alu   = (o >= 4'd3) && (o <= 4'd6);
    taken = (o == 4'd9) || (o == 4'd7 && !z) || (o == 4'd8 && z);
    if (o == 4'd15) begin
      for (int i = 0; i < tail; i++) push(B_HALTED, rb(), rb(), o);
    end else if (taken) begin
      push(P_BR, rb(), rb(), o);
    end else if (o == 4'd1 || alu) begin
      push(P_ADDR, rb(), rb(), o);
      push_mem(P_RDM, wx, o, err);
      if (err) begin
        for (int i = 0; i < tail; i++) push(B_BUS_ERR, rb(), rb(), o);
      end else begin
        ex = P_EX;
        if (alu) ex = ex | B_ALU_ACC | (17'(o - 4'd3) << 4);
        push(ex, rb(), rb(), o);
      end
    end else if (o == 4'd2) begin
      push(P_ADDR, rb(), rb(), o);
      push(P_WM0, rb(), rb(), o);
      push_mem(B_CS, wx, o, err);
      if (err) for (int i = 0; i < tail; i++) push(B_BUS_ERR, rb(), rb(), o);
    end
  endtask

  task automatic run_model(input string tag, input int limit);
    int n;
    logic [16:0] e;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(negedge clock);
      mem_ready = rdy_q.pop_front();
      z_flag    = z_q.pop_front();
      op        = op_q.pop_front();
      e         = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s cycle %0d strobes got %h expected %h", tag, n, obs, e);
      end
      @(posedge clock);
      #1;
      n++;
    end
    exp_q.delete();
    rdy_q.delete();
    z_q.delete();
    op_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    first_pending = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    checks += 3;
    if (obs !== 17'd0) begin
      failures++;
      $display("FAIL %s outputs got %h expected 0", tag, obs);
    end
    if (dut.r_state !== ST_FETCH_A) begin
      failures++;
      $display("FAIL %s state got %0d expected %0d", tag, dut.r_state, ST_FETCH_A);
    end
    if (dut.u_timer.r_cnt !== '0) begin
      failures++;
      $display("FAIL %s wait_cnt got %0d expected 0", tag, dut.u_timer.r_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_state("reset");
    build(4'd0, 1'b0, 0, 0, 0);
    run_model("reset_nop", 1000);
  endtask

  task automatic test_reset_mid_access();
    // LOAD stalls in RD_M: FA FM FI DEC RA then three not-ready RD_M cycles
    build(4'd1, 1'b0, 0, 20, 0);
    run_model("mid_access", 8);
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_state("reset_mid_rdm");
    @(posedge clock);
    #1 reset = 1'b0;
    first_pending = 1'b1;
  endtask

  task automatic test_load();
    build(4'd0, 1'b0, 0, 0, 0);
    build(4'd1, 1'b0, 0, 0, 0);
    run_model("load", 1000);
  endtask

  task automatic test_add_wait();
    build(4'd3, 1'b1, 0, 3, 0);
    build(4'd4, 1'b0, 2, 1, 0);
    build(4'd5, 1'b0, 0, 0, 0);
    build(4'd6, 1'b1, 1, 2, 0);
    run_model("alu_wait", 1000);
  endtask

  task automatic test_branches();
    build(4'd7, 1'b0, 0, 0, 0);
    build(4'd7, 1'b1, 0, 0, 0);
    build(4'd8, 1'b0, 0, 0, 0);
    build(4'd8, 1'b1, 0, 0, 0);
    build(4'd9, 1'b1, 0, 0, 0);
    run_model("branch", 1000);
  endtask

  task automatic test_unlisted_nop();
    build(4'hA, 1'b0, 0, 0, 0);
    build(4'hE, 1'b1, 0, 0, 0);
    build(4'd2, 1'b0, 0, MAX_WAIT, 0);
    run_model("unlisted_nop", 1000);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [3:0] o;
      int wf;
      int wx;
      o  = 4'($urandom_range(0, 14));
      wf = ($urandom_range(0, 7) == 0) ? MAX_WAIT : int'($urandom_range(0, 4));
      wx = ($urandom_range(0, 7) == 0) ? MAX_WAIT : int'($urandom_range(0, 4));
      build(o, rb(), wf, wx, 0);
    end
    run_model("random", 100000);
  endtask

  task automatic test_store_timeout();
    build(4'd2, 1'b0, 0, MAX_WAIT + 1, 12);
    run_model("store_timeout", 1000);
    do_reset();
    build(4'd1, 1'b0, MAX_WAIT + 1, 0, 6);
    run_model("fetch_timeout", 1000);
  endtask

  task automatic test_halt();
    do_reset();
    build(4'd15, 1'b0, 1, 0, 25);
    run_model("halt", 1000);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    first_pending = 1'b0;
    reset         = 1'b1;
    op            = 4'd0;
    z_flag        = 1'b0;
    mem_ready     = 1'b0;
    test_reset();
    test_reset_mid_access();
    test_load();
    test_add_wait();
    test_branches();
    test_unlisted_nop();
    test_random();
    test_store_timeout();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
